// File: rtl/alu_pkg.sv
// Shared definitions for the iterative divider.
// Contents:
//   div_state_t    - divider FSM state encoding
//   DIV_ZERO_QUOT  - quotient returned on divide-by-zero (all ones, slice to width)
//   DIV_OVF_REM    - remainder returned on signed overflow (zero)
//   abs_val()      - magnitude of a w-bit value, treated as two's complement
//                    when is_signed is set and as unsigned otherwise
package alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Widest operand abs_val() can handle.
  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] DIV_ZERO_QUOT = '1;
  localparam logic [MAX_W-1:0] DIV_OVF_REM   = '0;

  // The caller zero-extends x into MAX_W bits and truncates the result back
  // to w bits. Bits above w are masked off so that negation cannot leak into
  // them.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                               input int                w,
                                               input logic              is_signed);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] res;
    for (int i = 0; i < MAX_W; i++) begin
      mask[i] = (i < w);
    end
    if (is_signed && x[w-1]) begin
      res = (~x + 1'b1) & mask;
    end else begin
      res = x & mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_iter_multi_if.sv
// Handshake and data bundle of the iterative divider.
// master: the issue side; it drives the request and observes the status and results.
// slave : the divider.
//   start_i, signed_i, dividend_i, divisor_i, cancel_i : request and flush
//   busy_o, done_o, quotient_o, remainder_o, div_zero_o : status and results
interface div_iter_multi_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             cancel_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, cancel_i,
    input  busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, cancel_i,
    output busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );
endinterface

// File: rtl/div_iter_multi_div_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder. It is always smaller than divisor.
//   bit_in  : next dividend bit, shifted in at the LSB
//   divisor : divisor magnitude
//   rem_out : next partial remainder
//   q_bit   : quotient bit for this step
module div_iter_multi_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  // The shifted value needs WIDTH+1 bits. rem_in can be close to 2^WIDTH
  // when the unsigned divisor is large.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    // When q_bit is set the true difference is below divisor, so the
    // difference modulo 2^WIDTH is exact.
    diff    = shifted[WIDTH-1:0] - divisor;
    rem_out = q_bit ? diff : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/div_iter_multi.sv
// Iterative radix-2 restoring divider with signed and unsigned modes.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : div_iter_multi_if.slave (start/cancel request, busy/done status,
//          quotient, remainder, div_zero)
// Results are valid while done_o pulses and are held until the next done_o.
//
// state | meaning
// IDLE  | waiting for start_i
// PREP  | take operand magnitudes, detect the special cases
// CALC  | WIDTH restoring iterations, MSB first
// FIX   | apply the signs to the quotient and the remainder
// DONE  | done_o pulse, results registered
module div_iter_multi
  import alu_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input logic            clk,
  input logic            rst,
  div_iter_multi_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state, state_nxt;

  logic [WIDTH-1:0] dividend_r, divisor_r;
  logic             sgn_r;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             q_neg, r_neg, zero_r;
  logic [WIDTH-1:0] rem_r, q_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quot_r, remd_r;
  logic             dz_r;

  logic             accept, is_zero, is_ovf, special;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign accept  = (state == IDLE) && bus.start_i && !bus.cancel_i;
  assign is_zero = (divisor_r == '0);
  assign is_ovf  = sgn_r && (dividend_r == MIN_NEG) && (divisor_r == '1);
  assign special = FAST_SPECIAL && (is_zero || is_ovf);

  div_iter_multi_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (a_abs[cnt]),
    .divisor (b_abs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = PREP;
      PREP: begin
        if (bus.cancel_i)  state_nxt = IDLE;
        else if (special)  state_nxt = DONE;
        else               state_nxt = CALC;
      end
      CALC: begin
        if (bus.cancel_i)   state_nxt = IDLE;
        else if (cnt == '0) state_nxt = FIX;
      end
      FIX:  state_nxt = bus.cancel_i ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dividend_r <= '0;
      divisor_r  <= '0;
      sgn_r      <= 1'b0;
      a_abs      <= '0;
      b_abs      <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      zero_r     <= 1'b0;
      rem_r      <= '0;
      q_r        <= '0;
      cnt        <= '0;
      quot_r     <= '0;
      remd_r     <= '0;
      dz_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dividend_r <= bus.dividend_i;
            divisor_r  <= bus.divisor_i;
            sgn_r      <= bus.signed_i;
          end
        end
        PREP: begin
          if (!bus.cancel_i) begin
            a_abs  <= WIDTH'(abs_val(MAX_W'(dividend_r), WIDTH, sgn_r));
            b_abs  <= WIDTH'(abs_val(MAX_W'(divisor_r), WIDTH, sgn_r));
            q_neg  <= sgn_r && (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]);
            r_neg  <= sgn_r && dividend_r[WIDTH-1];
            zero_r <= is_zero;
            cnt    <= CW'(WIDTH - 1);
            rem_r  <= '0;
            q_r    <= '0;
            if (FAST_SPECIAL && is_zero) begin
              quot_r <= WIDTH'(DIV_ZERO_QUOT);
              remd_r <= dividend_r;
              dz_r   <= 1'b1;
            end else if (FAST_SPECIAL && is_ovf) begin
              quot_r <= MIN_NEG;
              remd_r <= WIDTH'(DIV_OVF_REM);
              dz_r   <= 1'b0;
            end
          end
        end
        CALC: begin
          if (!bus.cancel_i) begin
            rem_r <= step_rem;
            q_r   <= {q_r[WIDTH-2:0], step_q};
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (!bus.cancel_i) begin
            // The iterations give q = all ones and rem = |a| for a zero
            // divisor. Both are overridden here so that the slow path
            // returns the same results as the fast path.
            if (zero_r) begin
              quot_r <= WIDTH'(DIV_ZERO_QUOT);
              remd_r <= dividend_r;
              dz_r   <= 1'b1;
            end else begin
              quot_r <= q_neg ? -q_r : q_r;
              remd_r <= r_neg ? -rem_r : rem_r;
              dz_r   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = (state == PREP) || (state == CALC) || (state == FIX);
  assign bus.done_o      = (state == DONE);
  assign bus.quotient_o  = quot_r;
  assign bus.remainder_o = remd_r;
  assign bus.div_zero_o  = dz_r;

endmodule

// File: tb/tb_div_iter_multi.sv
// Testbench for div_iter_multi. It runs a 32-bit instance, an 8-bit fast-special
// instance and an 8-bit slow-special instance. All results are compared against
// an arithmetic reference model.
module tb_div_iter_multi;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_iter_multi_if #(.WIDTH(32)) bus32 ();
  div_iter_multi_if #(.WIDTH(8))  bus8 ();
  div_iter_multi_if #(.WIDTH(8))  bus8n ();

  div_iter_multi #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  div_iter_multi #(.WIDTH(8),  .FAST_SPECIAL(1'b1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  div_iter_multi #(.WIDTH(8),  .FAST_SPECIAL(1'b0)) dut8n (.clk(clk), .rst(rst), .bus(bus8n));

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 5000000", $time);
    $fatal(1);
  end

  // Truncating division with the defined special cases.
  task automatic model(input bit s, input int w, input longint unsigned a, input longint unsigned b,
                       output longint unsigned q, output longint unsigned r, output bit z);
    longint unsigned mask;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    if (b == 0) begin
      q = mask; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa = (a >= (64'd1 << (w-1))) ? $signed(a) - $signed(64'd1 << w) : $signed(a);
      sb = (b >= (64'd1 << (w-1))) ? $signed(b) - $signed(64'd1 << w) : $signed(b);
      z = 1'b0;
      if (sa == -$signed(64'd1 << (w-1)) && sb == -64'sd1) begin
        q = a; r = 0;
      end else begin
        q = $unsigned(sa / sb) & mask;
        r = $unsigned(sa % sb) & mask;
      end
    end
  endtask

  // After this task the edge that accepted the request (T) has passed, and
  // the time is 1 ns later.
  task automatic start32(input bit s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus32.signed_i = s; bus32.dividend_i = a; bus32.divisor_i = b; bus32.start_i = 1'b1;
    @(posedge clk); #1;
    bus32.start_i = 1'b0;
  endtask

  // lat counts edges with T as 1. It reaches the value of the edge that raised done_o.
  task automatic run32(input bit s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z,
                       output int lat, output bit busy_ok, output logic busy_at_done, output bit to);
    start32(s, a, b);
    lat = 1; busy_ok = 1'b1; to = 1'b1; busy_at_done = 1'bx;
    q = 'x; r = 'x; z = 1'bx;
    for (int i = 0; i < 200; i++) begin
      if (bus32.done_o === 1'b1) begin
        to = 1'b0; q = bus32.quotient_o; r = bus32.remainder_o; z = bus32.div_zero_o;
        busy_at_done = bus32.busy_o;
        break;
      end
      if (bus32.busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] qf, output logic [7:0] rf, output logic zf, output int latf,
                      output logic [7:0] qs, output logic [7:0] rs, output logic zs, output int lats,
                      output bit to);
    bit df, ds;
    int n;
    @(posedge clk); #1;
    bus8.signed_i  = s; bus8.dividend_i  = a; bus8.divisor_i  = b; bus8.start_i  = 1'b1;
    bus8n.signed_i = s; bus8n.dividend_i = a; bus8n.divisor_i = b; bus8n.start_i = 1'b1;
    @(posedge clk); #1;
    bus8.start_i = 1'b0; bus8n.start_i = 1'b0;
    df = 1'b0; ds = 1'b0; n = 1; latf = 0; lats = 0;
    qf = 'x; rf = 'x; zf = 1'bx; qs = 'x; rs = 'x; zs = 1'bx;
    for (int i = 0; i < 100; i++) begin
      if (!df && bus8.done_o === 1'b1) begin
        df = 1'b1; latf = n; qf = bus8.quotient_o; rf = bus8.remainder_o; zf = bus8.div_zero_o;
      end
      if (!ds && bus8n.done_o === 1'b1) begin
        ds = 1'b1; lats = n; qs = bus8n.quotient_o; rs = bus8n.remainder_o; zs = bus8n.div_zero_o;
      end
      if (df && ds) break;
      @(posedge clk); #1;
      n++;
    end
    to = !(df && ds);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus32.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus32.busy_o); end
    checks++; if (bus32.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus32.done_o); end
    checks++; if (bus32.quotient_o !== 32'h0) begin errors++; $display("FAIL reset_quot: got %h want 0", bus32.quotient_o); end
    checks++; if (bus32.remainder_o !== 32'h0) begin errors++; $display("FAIL reset_rem: got %h want 0", bus32.remainder_o); end
    checks++; if (bus32.div_zero_o !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", bus32.div_zero_o); end
    checks++; if ({bus8.busy_o, bus8.done_o, bus8n.busy_o, bus8n.done_o} !== 4'b0) begin
      errors++; $display("FAIL reset_8bit_status: got %b want 0000", {bus8.busy_o, bus8.done_o, bus8n.busy_o, bus8n.done_o});
    end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] q, r; logic z, bd; int lat; bit bok, to;
    run32(1'b1, 32'd100, 32'd7, q, r, z, lat, bok, bd, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: no done_o within 200 cycles"); end
    checks++; if (lat != 35) begin errors++; $display("FAIL basic_latency: got %0d want 35", lat); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL basic_quot: got %h want %h", q, 32'd14); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL basic_rem: got %h want %h", r, 32'd2); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL basic_dz: got %b want 0", z); end
    checks++; if (!bok) begin errors++; $display("FAIL basic_busy_during: busy_o dropped before done_o, want 1"); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", bd); end
  endtask

  task automatic test_signed;
    logic [31:0] q, r; logic z, bd; int lat; bit bok, to;
    run32(1'b1, -32'sd100, 32'd7, q, r, z, lat, bok, bd, to);
    checks++; if (to || q !== 32'hFFFFFFF2 || r !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL signed_neg: got q=%h r=%h to=%0d want q=fffffff2 r=fffffffe", q, r, to);
    end
    run32(1'b0, 32'hFFFFFFF0, 32'd16, q, r, z, lat, bok, bd, to);
    checks++; if (to || q !== 32'h0FFFFFFF || r !== 32'h0 || lat != 35) begin
      errors++; $display("FAIL unsigned_big: got q=%h r=%h lat=%0d want q=0fffffff r=0 lat=35", q, r, lat);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] q, r; logic z, bd; int lat; bit bok, to;
    run32(1'b1, 32'h12345678, 32'h0, q, r, z, lat, bok, bd, to);
    checks++; if (to || lat != 2) begin errors++; $display("FAIL dz_latency: got %0d to=%0d want 2", lat, to); end
    checks++; if (q !== 32'hFFFFFFFF || r !== 32'h12345678 || z !== 1'b1) begin
      errors++; $display("FAIL dz_result: got q=%h r=%h z=%b want q=ffffffff r=12345678 z=1", q, r, z);
    end
    run32(1'b1, 32'hFFFFFFFB, 32'h0, q, r, z, lat, bok, bd, to);
    checks++; if (to || q !== 32'hFFFFFFFF || r !== 32'hFFFFFFFB || z !== 1'b1) begin
      errors++; $display("FAIL dz_negative: got q=%h r=%h z=%b want q=ffffffff r=fffffffb z=1", q, r, z);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] q, r; logic z, bd; int lat; bit bok, to;
    run32(1'b1, 32'h80000000, 32'hFFFFFFFF, q, r, z, lat, bok, bd, to);
    checks++; if (to || lat != 2 || q !== 32'h80000000 || r !== 32'h0 || z !== 1'b0) begin
      errors++; $display("FAIL ovf_signed: got q=%h r=%h z=%b lat=%0d want q=80000000 r=0 z=0 lat=2", q, r, z, lat);
    end
    run32(1'b0, 32'h80000000, 32'hFFFFFFFF, q, r, z, lat, bok, bd, to);
    checks++; if (to || lat != 35 || q !== 32'h0 || r !== 32'h80000000 || z !== 1'b0) begin
      errors++; $display("FAIL ovf_unsigned: got q=%h r=%h z=%b lat=%0d want q=0 r=80000000 z=0 lat=35", q, r, z, lat);
    end
  endtask

  task automatic test_hold;
    bit bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus32.done_o !== 1'b0 || bus32.quotient_o !== 32'h0 || bus32.remainder_o !== 32'h80000000) bad = 1'b1;
    end
    checks++; if (bad) begin
      errors++; $display("FAIL hold: got q=%h r=%h done=%b want q=0 r=80000000 done=0 for 10 cycles",
                         bus32.quotient_o, bus32.remainder_o, bus32.done_o);
    end
  endtask

  task automatic test_cancel;
    bit seen; int n;
    start32(1'b1, 32'd100, 32'd7);
    repeat (10) @(posedge clk); #1;
    bus32.cancel_i = 1'b1;
    @(posedge clk); #1;
    bus32.cancel_i = 1'b0;
    checks++; if (bus32.busy_o !== 1'b0 || bus32.done_o !== 1'b0) begin
      errors++; $display("FAIL cancel_status: got busy=%b done=%b want 0 0", bus32.busy_o, bus32.done_o);
    end
    checks++; if (bus32.quotient_o !== 32'h0 || bus32.remainder_o !== 32'h80000000) begin
      errors++; $display("FAIL cancel_outputs: got q=%h r=%h want q=0 r=80000000", bus32.quotient_o, bus32.remainder_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (bus32.done_o === 1'b1 || bus32.busy_o === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL cancel_no_done: got activity after cancel, want none"); end

    // A start pulse in the middle of an operation is ignored and not queued.
    start32(1'b1, 32'd9, 32'd2);
    repeat (4) @(posedge clk); #1;
    bus32.start_i = 1'b1; bus32.dividend_i = 32'd50; bus32.divisor_i = 32'd3;
    @(posedge clk); #1;
    bus32.start_i = 1'b0;
    n = 6; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus32.done_o === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      n++;
    end
    checks++; if (!seen || n != 35) begin errors++; $display("FAIL restart_latency: got %0d seen=%0d want 35", n, seen); end
    checks++; if (bus32.quotient_o !== 32'd4 || bus32.remainder_o !== 32'd1) begin
      errors++; $display("FAIL restart_result: got q=%h r=%h want q=4 r=1", bus32.quotient_o, bus32.remainder_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus32.done_o === 1'b1 || bus32.busy_o === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL ignored_start: got a queued operation, want none"); end
  endtask

  task automatic test_cancel_done;
    start32(1'b0, 32'd1000, 32'd10);
    repeat (34) @(posedge clk); #1;
    bus32.cancel_i = 1'b1;
    #1;
    checks++; if (bus32.done_o !== 1'b1 || bus32.quotient_o !== 32'd100 || bus32.remainder_o !== 32'd0) begin
      errors++; $display("FAIL cancel_in_done: got done=%b q=%h r=%h want done=1 q=64 r=0",
                         bus32.done_o, bus32.quotient_o, bus32.remainder_o);
    end
    @(posedge clk); #1;
    bus32.cancel_i = 1'b0;
    checks++; if (bus32.done_o !== 1'b0 || bus32.busy_o !== 1'b0 || bus32.quotient_o !== 32'd100) begin
      errors++; $display("FAIL after_cancel_done: got done=%b busy=%b q=%h want 0 0 64",
                         bus32.done_o, bus32.busy_o, bus32.quotient_o);
    end
  endtask

  task automatic test_start_cancel_idle;
    bit seen = 1'b0;
    @(posedge clk); #1;
    bus32.dividend_i = 32'd77; bus32.divisor_i = 32'd5;
    bus32.start_i = 1'b1; bus32.cancel_i = 1'b1;
    @(posedge clk); #1;
    bus32.start_i = 1'b0; bus32.cancel_i = 1'b0;
    checks++; if (bus32.busy_o !== 1'b0) begin errors++; $display("FAIL start_cancel_busy: got %b want 0", bus32.busy_o); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus32.done_o === 1'b1 || bus32.busy_o === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL start_cancel_no_op: got an operation, want none"); end
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    start32(1'b1, 32'd100, 32'd7);
    repeat (8) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({bus32.busy_o, bus32.done_o, bus32.div_zero_o} !== 3'b0 ||
                  bus32.quotient_o !== 32'h0 || bus32.remainder_o !== 32'h0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                         bus32.busy_o, bus32.done_o, bus32.div_zero_o, bus32.quotient_o, bus32.remainder_o);
    end
    rst = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (bus32.done_o === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL reset_mid_no_done: got done_o after reset, want none"); end
  endtask

  task automatic test_random32;
    logic [31:0] a, b, q, r; logic z, bd; int lat; bit bok, to, s;
    longint unsigned eq, er; bit ez;
    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      model(s, 32, longint'(a), longint'(b), eq, er, ez);
      run32(s, a, b, q, r, z, lat, bok, bd, to);
      checks++;
      if (to || q !== 32'(eq) || r !== 32'(er) || z !== ez) begin
        errors++; $display("FAIL random32 s=%0d a=%h b=%h: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                           s, a, b, q, r, z, 32'(eq), 32'(er), ez);
      end
    end
  endtask

  task automatic sweep_one(input bit s, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] qf, rf, qs, rs; logic zf, zs; int latf, lats; bit to, spec;
    longint unsigned eq, er; bit ez;
    model(s, 8, longint'(a), longint'(b), eq, er, ez);
    spec = (b == 8'h00) || (s && a == 8'h80 && b == 8'hFF);
    run8(s, a, b, qf, rf, zf, latf, qs, rs, zs, lats, to);
    checks++;
    if (to || qf !== 8'(eq) || rf !== 8'(er) || zf !== ez || latf != (spec ? 2 : 11)) begin
      errors++; $display("FAIL sweep8_fast s=%0d a=%h b=%h: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                         s, a, b, qf, rf, zf, latf, 8'(eq), 8'(er), ez, spec ? 2 : 11);
    end
    checks++;
    if (to || qs !== 8'(eq) || rs !== 8'(er) || zs !== ez || lats != 11) begin
      errors++; $display("FAIL sweep8_slow s=%0d a=%h b=%h: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=11",
                         s, a, b, qs, rs, zs, lats, 8'(eq), 8'(er), ez);
    end
  endtask

  task automatic test_sweep8;
    logic [7:0] ca [10] = '{8'h80, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'hFF, 8'h81, 8'h64, 8'h9C, 8'hC8};
    logic [7:0] cb [10] = '{8'hFF, 8'h00, 8'h80, 8'hC8, 8'h05, 8'h01, 8'h7F, 8'hF9, 8'h07, 8'hFE};
    logic [7:0] a, b;
    for (int i = 0; i < 10; i++) begin
      sweep_one(1'b0, ca[i], cb[i]);
      sweep_one(1'b1, ca[i], cb[i]);
    end
    for (int i = 0; i < 1200; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      sweep_one(1'($urandom_range(0, 1)), a, b);
    end
  endtask

  initial begin
    bus32.start_i = 1'b0; bus32.signed_i = 1'b0; bus32.dividend_i = '0; bus32.divisor_i = '0; bus32.cancel_i = 1'b0;
    bus8.start_i  = 1'b0; bus8.signed_i  = 1'b0; bus8.dividend_i  = '0; bus8.divisor_i  = '0; bus8.cancel_i  = 1'b0;
    bus8n.start_i = 1'b0; bus8n.signed_i = 1'b0; bus8n.dividend_i = '0; bus8n.divisor_i = '0; bus8n.cancel_i = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_hold();
    test_cancel();
    test_cancel_done();
    test_start_cancel_idle();
    test_reset_mid();
    test_random32();
    test_sweep8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
